// File: rtl/wb_victim_buffer_if.sv
// Cache-side and arbiter-side bus bundle for the write-back victim buffer.
// slave = buffer view, master = cache/arbiter environment view.
interface wb_victim_buffer_if #(
  parameter int LINE_BITS = 256
);
  logic                 cache_read;
  logic                 cache_write;
  logic [31:0]          cache_address;
  logic [LINE_BITS-1:0] cache_wdata;
  logic [LINE_BITS-1:0] cache_rdata;
  logic                 cache_resp;
  logic                 arb_read;
  logic                 arb_write;
  logic [31:0]          arb_address;
  logic [LINE_BITS-1:0] arb_wdata;
  logic [LINE_BITS-1:0] arb_rdata;
  logic                 arb_resp;

  modport slave (
    input  cache_read, cache_write,
    input  cache_address, cache_wdata,
    output cache_rdata, cache_resp,
    output arb_read, arb_write,
    output arb_address, arb_wdata,
    input  arb_rdata, arb_resp
  );

  modport master (
    output cache_read, cache_write,
    output cache_address, cache_wdata,
    input  cache_rdata, cache_resp,
    input  arb_read, arb_write,
    input  arb_address, arb_wdata,
    output arb_rdata, arb_resp
  );
endinterface

// File: rtl/wb_victim_buffer.sv
// Write-back victim buffer: FIFO of evicted lines, coalescing and read-forwarding.
// Optional perf counters enabled by WB_VICTIM_BUF_PERF_EN.
module wb_victim_buffer #(
  parameter int DEPTH       = 2,
  parameter int LINE_BITS   = 256,
  parameter int OFFSET_BITS = 5
) (
  input  logic clk,
  input  logic rst,
  wb_victim_buffer_if.slave vb
`ifdef WB_VICTIM_BUF_PERF_EN
  ,
  output logic [31:0] perf_read_hits,
  output logic [31:0] perf_coalesces,
  output logic [31:0] perf_full_stalls
`endif
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] LINE_MASK =
    ~((32'd1 << OFFSET_BITS) - 32'd1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACK   = 2'd1;
  localparam logic [1:0] S_RD    = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;

  logic                 valid_q [DEPTH];
  logic [31:0]          line_q  [DEPTH];
  logic [LINE_BITS-1:0] data_q  [DEPTH];

  logic [31:0]      req_line;
  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  logic             full;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic             inv_en;
  logic             ev_rd_hit;
  logic             ev_coal;
  logic             ev_stall;

  // Entries hold the masked line address; it doubles as the match tag.
  assign req_line = vb.cache_address & LINE_MASK;
  assign full     = (count_q == CNT_W'(DEPTH));

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && line_q[i] == req_line) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    rdata_d   = rdata_q;
    wr_en     = 1'b0;
    wr_idx    = tail_q;
    inv_en    = 1'b0;
    ev_rd_hit = 1'b0;
    ev_coal   = 1'b0;
    ev_stall  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (vb.cache_write) begin
          if (hit) begin
            wr_en   = 1'b1;
            wr_idx  = hit_idx;
            ev_coal = 1'b1;
            state_d = S_ACK;
          end else if (!full) begin
            wr_en   = 1'b1;
            tail_d  = tail_q + PTR_W'(1);
            count_d = count_q + CNT_W'(1);
            state_d = S_ACK;
          end else begin
            ev_stall = 1'b1;
            state_d  = S_DRAIN;
          end
        end else if (vb.cache_read) begin
          if (hit) begin
            rdata_d   = data_q[hit_idx];
            ev_rd_hit = 1'b1;
            state_d   = S_ACK;
          end else begin
            state_d = S_RD;
          end
        end else if (count_q != '0) begin
          state_d = S_DRAIN;
        end
      end
      S_ACK: state_d = S_IDLE;
      S_RD: begin
        if (vb.arb_resp) begin
          rdata_d = vb.arb_rdata;
          state_d = S_ACK;
        end
      end
      S_DRAIN: begin
        if (vb.arb_resp) begin
          inv_en  = 1'b1;
          head_d  = head_q + PTR_W'(1);
          count_d = count_q - CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        line_q[i]  <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
        line_q[wr_idx]  <= req_line;
        data_q[wr_idx]  <= vb.cache_wdata;
      end
      if (inv_en) valid_q[head_q] <= 1'b0;
    end
  end

  assign vb.cache_resp  = (state_q == S_ACK);
  assign vb.cache_rdata = rdata_q;
  assign vb.arb_read    = (state_q == S_RD);
  assign vb.arb_write   = (state_q == S_DRAIN);
  assign vb.arb_address = vb.arb_read  ? req_line :
                          vb.arb_write ? line_q[head_q] : '0;
  assign vb.arb_wdata   = vb.arb_write ? data_q[head_q] : '0;

`ifdef WB_VICTIM_BUF_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_read_hits   <= '0;
      perf_coalesces   <= '0;
      perf_full_stalls <= '0;
    end else begin
      if (ev_rd_hit && perf_read_hits != '1)
        perf_read_hits <= perf_read_hits + 32'd1;
      if (ev_coal && perf_coalesces != '1)
        perf_coalesces <= perf_coalesces + 32'd1;
      if (ev_stall && perf_full_stalls != '1)
        perf_full_stalls <= perf_full_stalls + 32'd1;
    end
  end
`endif
endmodule
